// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the RGB444 colour type
// used by the sync generator and its pixel-tick divider.
package vga_timing_pkg;

  localparam int PIX_DIV = 4;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: counts CLK cycles and flags the last cycle of every
// pixel period, which is where the timing counters advance.
module vga_pixel_tick
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = vga_timing_pkg::PIX_DIV
) (
  input  logic CLK,
  input  logic RESET,
  output logic PIX_TICK
);

  localparam int W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [W-1:0] DIV_LAST = W'(PIX_DIV - 1);

  logic [W-1:0] divcnt;

  always_ff @(posedge CLK) begin
    if (RESET)
      divcnt <= '0;
    else if (divcnt == DIV_LAST)
      divcnt <= '0;
    else
      divcnt <= divcnt + W'(1);
  end

  assign PIX_TICK = (divcnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel counters, combinational pixel address and a
// one-pixel output stage that keeps colour and HS/VS aligned at the pins.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = vga_timing_pkg::PIX_DIV,
  parameter int H_VIS   = vga_timing_pkg::H_VIS,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int V_VIS   = vga_timing_pkg::V_VIS,
  parameter int V_FP    = vga_timing_pkg::V_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP
) (
  input  logic        CLK,
  input  logic        RESET,
  input  rgb444_t     COLOUR_IN,
  output rgb444_t     COLOUR_OUT,
  output logic [9:0]  ADDRH,
  output logic [8:0]  ADDRV,
  output logic        HS,
  output logic        VS,
  output logic        PIX_TICK,
  output logic        FRAME_START
);

  localparam logic [9:0] H_VIS_C   = 10'(H_VIS);
  localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_SS      = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SE      = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS_C   = 10'(V_VIS);
  localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_SS      = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SE      = 10'(V_VIS + V_FP + V_SYNC);

  logic       pix_tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       h_wrap;
  logic       v_wrap;
  logic       h_vis;
  logic       v_vis;

  vga_pixel_tick #(.PIX_DIV(PIX_DIV)) u_pixel_tick (
    .CLK      (CLK),
    .RESET    (RESET),
    .PIX_TICK (pix_tick)
  );

  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);
  assign h_vis  = (hcount < H_VIS_C);
  assign v_vis  = (vcount < V_VIS_C);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_tick) begin
      if (h_wrap) begin
        hcount <= '0;
        vcount <= v_wrap ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // Sampled on the tick that leaves the current pixel, so the pins lag the
  // address by exactly one pixel while the display stage fetches the colour.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      COLOUR_OUT <= '0;
      HS         <= 1'b1;
      VS         <= 1'b1;
    end else if (pix_tick) begin
      COLOUR_OUT <= (h_vis && v_vis) ? COLOUR_IN : '0;
      HS         <= !((hcount >= H_SS) && (hcount < H_SE));
      VS         <= !((vcount >= V_SS) && (vcount < V_SE));
    end
  end

  assign ADDRH       = h_vis ? hcount : 10'd0;
  assign ADDRV       = v_vis ? vcount[8:0] : 9'd0;
  assign PIX_TICK    = pix_tick;
  assign FRAME_START = pix_tick && h_wrap && v_wrap;

endmodule
